// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator: op codes, FSM states, default width
// and small op-classification helpers.
package acc_pkg;

  localparam int unsigned ACC_WIDTH = 16;
  localparam int unsigned OP_W      = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 4'd0,
    OP_INC = 4'd1,
    OP_DEC = 4'd2,
    OP_SHL = 4'd3,
    OP_SHR = 4'd4,
    OP_NOT = 4'd5,
    OP_COM = 4'd6,
    OP_ASR = 4'd7,
    OP_ROL = 4'd8,
    OP_ROR = 4'd9,
    OP_ADC = 4'd10,
    OP_SBB = 4'd11
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Shift/rotate ops run one bit per step, shamt steps in total.
  function automatic logic is_shift(input logic [OP_W-1:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR) ||
           (op == OP_ROL) || (op == OP_ROR);
  endfunction

  // Codes 12..15 are unassigned and behave exactly like NOP.
  function automatic logic is_nop(input logic [OP_W-1:0] op);
    return (op == OP_NOP) || (op >= 4'd12);
  endfunction

endpackage

// File: rtl/acc_step.sv
// One combinational accumulator step: a full single-cycle op, or a single bit
// of a shift/rotate. Carry input is already initialised by the caller.
module acc_step
  import acc_pkg::*;
#(
  parameter int unsigned WIDTH = ACC_WIDTH
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] acc,
  input  logic             carry,
  input  logic [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] acc_next,
  output logic             carry_next
);

  localparam int unsigned XW = WIDTH + 1;

  logic [XW-1:0] sum;

  always_comb begin
    acc_next   = acc;
    carry_next = carry;
    sum        = '0;
    case (op)
      OP_INC: begin
        sum        = {1'b0, acc} + XW'(1);
        acc_next   = sum[WIDTH-1:0];
        carry_next = sum[WIDTH];
      end
      OP_DEC: begin
        sum        = {1'b0, acc} - XW'(1);
        acc_next   = sum[WIDTH-1:0];
        carry_next = sum[WIDTH];
      end
      OP_ADC: begin
        sum        = {1'b0, acc} + {1'b0, bus} + XW'(carry);
        acc_next   = sum[WIDTH-1:0];
        carry_next = sum[WIDTH];
      end
      // Top bit of the widened difference is the borrow out.
      OP_SBB: begin
        sum        = {1'b0, acc} - {1'b0, bus} - XW'(carry);
        acc_next   = sum[WIDTH-1:0];
        carry_next = sum[WIDTH];
      end
      OP_NOT: acc_next = ~acc;
      OP_COM: begin
        acc_next   = (~acc) + WIDTH'(1);
        carry_next = (acc == '0);
      end
      OP_SHL: begin
        carry_next = acc[WIDTH-1];
        acc_next   = {acc[WIDTH-2:0], 1'b0};
      end
      OP_SHR: begin
        carry_next = acc[0];
        acc_next   = {1'b0, acc[WIDTH-1:1]};
      end
      OP_ASR: begin
        carry_next = acc[0];
        acc_next   = {acc[WIDTH-1], acc[WIDTH-1:1]};
      end
      OP_ROL: {carry_next, acc_next} = {acc, carry};
      OP_ROR: {acc_next, carry_next} = {carry, acc};
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_unit.sv
// Accumulator register with carry flag, falling-edge clocked. Single-cycle ops
// complete at the start edge; multi-bit shifts step one bit per edge.
module acc_unit
  import acc_pkg::*;
#(
  parameter int unsigned WIDTH = ACC_WIDTH,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] bus,
  input  logic             flag_c_in,
  output logic [WIDTH-1:0] out,
  output logic             flag_c_out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [OP_W-1:0]  step_op;
  logic             step_cin;
  logic [WIDTH-1:0] step_acc;
  logic             step_cout;

  // Mid-shift the latched op and running carry feed the step; otherwise the
  // fresh op with carry initialised from flag_c_in.
  assign step_op  = (state_q == ST_SHIFT) ? op_q : op;
  assign step_cin = (state_q == ST_SHIFT) ? carry_q : flag_c_in;

  acc_step #(.WIDTH(WIDTH)) u_step (
    .op        (step_op),
    .acc       (acc_q),
    .carry     (step_cin),
    .bus       (bus),
    .acc_next  (step_acc),
    .carry_next(step_cout)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          acc_d = bus;
        end else if (start) begin
          op_d   = op;
          done_d = 1'b1;
          if (is_nop(op)) begin
            // acc and carry untouched
          end else if (is_shift(op)) begin
            if (shamt == '0) begin
              carry_d = flag_c_in;
            end else begin
              acc_d   = step_acc;
              carry_d = step_cout;
              if (shamt != SHW'(1)) begin
                state_d = ST_SHIFT;
                cnt_d   = shamt - SHW'(1);
                busy_d  = 1'b1;
                done_d  = 1'b0;
              end
            end
          end else begin
            acc_d   = step_acc;
            carry_d = step_cout;
          end
        end
      end
      ST_SHIFT: begin
        acc_d   = step_acc;
        carry_d = step_cout;
        cnt_d   = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out        = acc_q;
  assign flag_c_out = carry_q;
  assign flag_z     = (acc_q == '0);
  assign flag_n     = acc_q[WIDTH-1];
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_acc_unit.sv
// Directed bench for acc_unit: inputs change just after each falling edge and
// outputs are sampled 1ns after it.
module tb_acc_unit;
  import acc_pkg::*;

  localparam int unsigned W   = 16;
  localparam int unsigned SHW = $clog2(W);

  logic           clk = 1'b0;
  logic           rst, load, start, flag_c_in;
  logic [3:0]     op;
  logic [SHW-1:0] shamt;
  logic [W-1:0]   bus;
  logic [W-1:0]   out;
  logic           flag_c_out, flag_z, flag_n, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  acc_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .start     (start),
    .op        (op),
    .shamt     (shamt),
    .bus       (bus),
    .flag_c_in (flag_c_in),
    .out       (out),
    .flag_c_out(flag_c_out),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .busy      (busy),
    .done      (done)
  );

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; start = 1'b0; flag_c_in = 1'b0;
    op = 4'd0; shamt = '0; bus = '0;
    tick(); tick();
    rst = 1'b0;

    // reset after a load
    load = 1'b1; bus = 16'h1234; tick();
    load = 1'b0;
    check("load_val", 32'(out), 32'h1234);
    check("load_nodone", 32'(done), 32'h0);
    rst = 1'b1; tick();
    rst = 1'b0;
    check("rst_out", 32'(out), 32'h0);
    check("rst_c", 32'(flag_c_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_z", 32'(flag_z), 32'h1);

    // INC wrap
    load = 1'b1; bus = 16'hFFFF; tick();
    load = 1'b0; start = 1'b1; op = 4'(OP_INC); tick();
    start = 1'b0;
    check("inc_out", 32'(out), 32'h0);
    check("inc_c", 32'(flag_c_out), 32'h1);
    check("inc_z", 32'(flag_z), 32'h1);
    check("inc_done", 32'(done), 32'h1);
    check("inc_busy", 32'(busy), 32'h0);
    tick();
    check("inc_done_off", 32'(done), 32'h0);
    check("inc_busy_off", 32'(busy), 32'h0);

    // ROL through carry by 3
    load = 1'b1; bus = 16'h8001; tick();
    load = 1'b0; flag_c_in = 1'b0; start = 1'b1; op = 4'(OP_ROL); shamt = 4'd3; tick();
    start = 1'b0;
    check("rol_busy1", 32'(busy), 32'h1);
    check("rol_mid1", {15'h0, flag_c_out, out}, {15'h0, 1'b1, 16'h0002});
    tick();
    check("rol_busy2", 32'(busy), 32'h1);
    check("rol_done_early", 32'(done), 32'h0);
    tick();
    check("rol_out", 32'(out), 32'h000A);
    check("rol_c", 32'(flag_c_out), 32'h0);
    check("rol_done", 32'(done), 32'h1);
    check("rol_busy_off", 32'(busy), 32'h0);
    tick();
    check("rol_done_off", 32'(done), 32'h0);

    // ASR by 4 with load and start requests while busy
    load = 1'b1; bus = 16'h8000; tick();
    load = 1'b0; start = 1'b1; op = 4'(OP_ASR); shamt = 4'd4; tick();
    start = 1'b0;
    check("asr_busy", 32'(busy), 32'h1);
    load = 1'b1; bus = 16'h5555; start = 1'b1; op = 4'(OP_INC); tick();
    load = 1'b0; start = 1'b0; bus = '0;
    check("asr_mid", 32'(out), 32'hE000);
    tick(); tick();
    check("asr_out", 32'(out), 32'hF800);
    check("asr_c", 32'(flag_c_out), 32'h0);
    check("asr_done", 32'(done), 32'h1);
    tick();
    check("asr_idle", 32'(out), 32'hF800);

    // ADC then SBB
    load = 1'b1; bus = 16'hFFFE; tick();
    load = 1'b0; bus = 16'h0001; flag_c_in = 1'b1; start = 1'b1; op = 4'(OP_ADC); tick();
    start = 1'b0;
    check("adc_out", 32'(out), 32'h0);
    check("adc_c", 32'(flag_c_out), 32'h1);
    load = 1'b1; bus = 16'h0000; tick();
    load = 1'b0; bus = 16'h0001; flag_c_in = 1'b0; start = 1'b1; op = 4'(OP_SBB); tick();
    start = 1'b0;
    check("sbb_out", 32'(out), 32'hFFFF);
    check("sbb_c", 32'(flag_c_out), 32'h1);
    check("sbb_n", 32'(flag_n), 32'h1);

    // COM of nonzero clears carry even with flag_c_in set
    flag_c_in = 1'b1; start = 1'b1; op = 4'(OP_COM); tick();
    start = 1'b0;
    check("com_out", 32'(out), 32'h0001);
    check("com_c", 32'(flag_c_out), 32'h0);

    // reset on the 3rd edge of an 8-bit SHR
    load = 1'b1; bus = 16'hF0F0; tick();
    load = 1'b0; flag_c_in = 1'b0; start = 1'b1; op = 4'(OP_SHR); shamt = 4'd8; tick();
    start = 1'b0;
    tick();
    check("shr_mid", 32'(out), 32'h3C3C);
    rst = 1'b1; tick();
    rst = 1'b0;
    check("mrst_out", 32'(out), 32'h0);
    check("mrst_c", 32'(flag_c_out), 32'h0);
    check("mrst_busy", 32'(busy), 32'h0);
    check("mrst_done", 32'(done), 32'h0);
    tick();
    check("mrst_done2", 32'(done), 32'h0);
    check("mrst_busy2", 32'(busy), 32'h0);

    // load and start together: only the load happens
    load = 1'b1; start = 1'b1; op = 4'(OP_INC); bus = 16'h00AB; tick();
    load = 1'b0; start = 1'b0;
    check("coll_out", 32'(out), 32'h00AB);
    check("coll_done", 32'(done), 32'h0);
    tick();
    check("coll_out2", 32'(out), 32'h00AB);
    check("coll_done2", 32'(done), 32'h0);

    // shamt 0: acc kept, carry from flag_c_in
    flag_c_in = 1'b1; start = 1'b1; op = 4'(OP_SHL); shamt = 4'd0; tick();
    start = 1'b0;
    check("sh0_out", 32'(out), 32'h00AB);
    check("sh0_c", 32'(flag_c_out), 32'h1);
    check("sh0_done", 32'(done), 32'h1);

    // NOP (code 13) keeps carry regardless of flag_c_in
    flag_c_in = 1'b0; start = 1'b1; op = 4'd13; tick();
    start = 1'b0;
    check("nop_c", 32'(flag_c_out), 32'h1);
    check("nop_out", 32'(out), 32'h00AB);
    check("nop_done", 32'(done), 32'h1);

    // DEC below zero sets carry
    load = 1'b1; bus = 16'h0000; tick();
    load = 1'b0; start = 1'b1; op = 4'(OP_DEC); tick();
    start = 1'b0;
    check("dec_out", 32'(out), 32'hFFFF);
    check("dec_c", 32'(flag_c_out), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
